// File: rtl/drop_ctrl.sv
`default_nettype none
// ===========================================================================
// drop_ctrl : turns auto-drop ticks into board checks, piece moves and locks
// Revision  : 1.0
// ===========================================================================
module drop_ctrl #(
   parameter int ROWS      = 20,
   parameter int ROW_W     = 5,
   parameter int SPAWN_ROW = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             move_sig,
   output logic             chk_req,
   output logic [ROW_W-1:0] chk_row,
   input  logic             chk_ack,
   input  logic             chk_hit,
   input  logic             clear_done,
   output logic [ROW_W-1:0] piece_row,
   output logic             lock,
   output logic             spawned,
   output logic             game_over,
   output logic [7:0]       miss_cnt
);

   typedef enum logic [2:0] {
      ST_STOP  = 3'd0,
      ST_SPAWN = 3'd1,
      ST_RUN   = 3'd2,
      ST_CHECK = 3'd3,
      ST_LOCK  = 3'd4,
      ST_CLEAR = 3'd5,
      ST_OVER  = 3'd6
   } state_t;

   localparam logic [ROW_W-1:0] C_FLOOR = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] C_SPAWN = ROW_W'(SPAWN_ROW);

   state_t           state_q, state_d;
   logic             chk_req_q, chk_req_d;
   logic [ROW_W-1:0] chk_row_q, chk_row_d;
   logic [ROW_W-1:0] piece_row_q, piece_row_d;
   logic             lock_q, lock_d;
   logic             spawned_q, spawned_d;
   logic             game_over_q, game_over_d;
   logic [7:0]       miss_q, miss_d;
   logic             w_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_STOP;
         chk_req_q   <= 1'b0;
         chk_row_q   <= '0;
         piece_row_q <= C_SPAWN;
         lock_q      <= 1'b0;
         spawned_q   <= 1'b0;
         game_over_q <= 1'b0;
         miss_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         chk_req_q   <= chk_req_d;
         chk_row_q   <= chk_row_d;
         piece_row_q <= piece_row_d;
         lock_q      <= lock_d;
         spawned_q   <= spawned_d;
         game_over_q <= game_over_d;
         miss_q      <= miss_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      chk_req_d   = chk_req_q;
      chk_row_d   = chk_row_q;
      piece_row_d = piece_row_q;
      lock_d      = 1'b0;
      spawned_d   = 1'b0;
      game_over_d = game_over_q;
      miss_d      = miss_q;

      // Ticks that arrive while a check, lock or clear is in flight are lost.
      w_busy = (state_q == ST_SPAWN) || (state_q == ST_CHECK) ||
               (state_q == ST_LOCK)  || (state_q == ST_CLEAR);
      if (move_sig && w_busy && (miss_q != 8'hFF)) begin
         miss_d = miss_q + 8'd1;
      end

      case (state_q)
         ST_STOP, ST_OVER: begin
            if (start) begin
               state_d     = ST_SPAWN;
               chk_req_d   = 1'b1;
               chk_row_d   = C_SPAWN;
               miss_d      = 8'd0;
               game_over_d = 1'b0;
            end
         end
         ST_SPAWN: begin
            if (chk_ack) begin
               chk_req_d = 1'b0;
               if (chk_hit) begin
                  state_d     = ST_OVER;
                  game_over_d = 1'b1;
               end else begin
                  state_d     = ST_RUN;
                  piece_row_d = C_SPAWN;
                  spawned_d   = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (move_sig) begin
               if (piece_row_q < C_FLOOR) begin
                  state_d   = ST_CHECK;
                  chk_req_d = 1'b1;
                  chk_row_d = piece_row_q + 1'b1;
               end else begin
                  state_d = ST_LOCK;
                  lock_d  = 1'b1;
               end
            end
         end
         ST_CHECK: begin
            if (chk_ack) begin
               chk_req_d = 1'b0;
               if (chk_hit) begin
                  state_d = ST_LOCK;
                  lock_d  = 1'b1;
               end else begin
                  state_d     = ST_RUN;
                  piece_row_d = chk_row_q;
               end
            end
         end
         ST_LOCK: begin
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (clear_done) begin
               state_d   = ST_SPAWN;
               chk_req_d = 1'b1;
               chk_row_d = C_SPAWN;
            end
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
   end

   assign chk_req   = chk_req_q;
   assign chk_row   = chk_row_q;
   assign piece_row = piece_row_q;
   assign lock      = lock_q;
   assign spawned   = spawned_q;
   assign game_over = game_over_q;
   assign miss_cnt  = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_drop_ctrl.sv
`default_nettype none
// ===========================================================================
// tb_drop_ctrl : directed stimulus for drop_ctrl against a behavioural model
// Revision     : 1.0
// ===========================================================================
module tb_drop_ctrl;

   localparam int ROWS  = 20;
   localparam int ROW_W = 5;
   localparam int SPAWN = 0;

   logic             clk        = 1'b0;
   logic             reset      = 1'b1;
   logic             start      = 1'b0;
   logic             move_sig   = 1'b0;
   logic             chk_ack    = 1'b0;
   logic             chk_hit    = 1'b0;
   logic             clear_done = 1'b0;
   logic             chk_req;
   logic [ROW_W-1:0] chk_row;
   logic [ROW_W-1:0] piece_row;
   logic             lock;
   logic             spawned;
   logic             game_over;
   logic [7:0]       miss_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   drop_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .SPAWN_ROW(SPAWN)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .move_sig   (move_sig),
      .chk_req    (chk_req),
      .chk_row    (chk_row),
      .chk_ack    (chk_ack),
      .chk_hit    (chk_hit),
      .clear_done (clear_done),
      .piece_row  (piece_row),
      .lock       (lock),
      .spawned    (spawned),
      .game_over  (game_over),
      .miss_cnt   (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Game model: which question is pending with the board, and the lost-tick tally.
   bit m_idle, m_over, m_query, m_spawnq, m_live, m_locking, m_clearing;
   bit m_lock, m_spawned;
   int m_qrow, m_row, m_miss;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_idle <= 1; m_over <= 0; m_query <= 0; m_spawnq <= 0; m_live <= 0;
         m_locking <= 0; m_clearing <= 0; m_lock <= 0; m_spawned <= 0;
         m_qrow <= 0; m_row <= SPAWN; m_miss <= 0;
      end else begin
         m_lock    <= 0;
         m_spawned <= 0;
         if (move_sig && (m_query || m_locking || m_clearing))
            m_miss <= (m_miss >= 255) ? 255 : m_miss + 1;
         if (m_idle || m_over) begin
            if (start) begin
               m_idle <= 0; m_over <= 0; m_miss <= 0;
               m_query <= 1; m_spawnq <= 1; m_qrow <= SPAWN;
            end
         end else if (m_query) begin
            if (chk_ack) begin
               m_query <= 0;
               if (m_spawnq && chk_hit) m_over <= 1;
               else if (m_spawnq) begin m_live <= 1; m_row <= SPAWN; m_spawned <= 1; end
               else if (chk_hit) begin m_locking <= 1; m_lock <= 1; end
               else begin m_live <= 1; m_row <= m_qrow; end
            end
         end else if (m_live) begin
            if (move_sig) begin
               m_live <= 0;
               if (m_row + 1 <= ROWS - 1) begin
                  m_query <= 1; m_spawnq <= 0; m_qrow <= m_row + 1;
               end else begin
                  m_locking <= 1; m_lock <= 1;
               end
            end
         end else if (m_locking) begin
            m_locking <= 0; m_clearing <= 1;
         end else if (m_clearing) begin
            if (clear_done) begin
               m_clearing <= 0; m_query <= 1; m_spawnq <= 1; m_qrow <= SPAWN;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("chk_req", chk_req, m_query);
      if (m_query) chk("chk_row", chk_row, m_qrow);
      chk("piece_row", piece_row, m_row);
      chk("lock", lock, m_lock);
      chk("spawned", spawned, m_spawned);
      chk("game_over", game_over, m_over);
      chk("miss_cnt", miss_cnt, m_miss);
      chk("lock_and_spawned", lock & spawned, 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds move_sig and answers every check at once until the piece reaches row.
   task automatic fall_to(input int row);
      int budget;
      budget   = 0;
      move_sig = 1;
      while (piece_row != row && budget < 200) begin
         chk_ack = chk_req;
         chk_hit = 0;
         tick();
         budget++;
      end
      chk_ack  = 0;
      move_sig = 0;
      chk("fall_to_row", piece_row, row);
   endtask

   initial begin
      int budget;
      tick(); tick();
      reset = 0;
      tick();
      chk("rst_piece_row", piece_row, 0);
      chk("rst_chk_req", chk_req, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_miss", miss_cnt, 0);

      // single tick, late ack
      start = 1; tick(); start = 0;
      chk("spawn_req", chk_req, 1);
      chk("spawn_row", chk_row, 0);
      chk_ack = 1; tick(); chk_ack = 0;
      chk("spawned_pulse", spawned, 1);
      move_sig = 1; tick(); move_sig = 0;
      chk("t1_chk_row", chk_row, 1);
      tick(); tick();
      chk("t1_chk_row_held", chk_row, 1);
      chk_ack = 1; tick(); chk_ack = 0;
      chk("t1_piece_row", piece_row, 1);
      chk("t1_req_low", chk_req, 0);

      // fast drop to the floor
      move_sig = 1;
      budget = 0;
      while (!lock && budget < 200) begin
         chk_ack = chk_req; chk_hit = 0;
         tick();
         budget++;
      end
      chk_ack = 0; move_sig = 0;
      chk("t2_lock", lock, 1);
      chk("t2_floor_row", piece_row, 19);
      chk("t2_miss", miss_cnt, 18);
      tick();
      clear_done = 1; tick(); clear_done = 0;
      chk_ack = 1; tick(); chk_ack = 0;
      fall_to(7);

      // blocked move locks in place, then respawn after clear
      move_sig = 1; tick(); move_sig = 0;
      chk("t3_chk_row", chk_row, 8);
      chk_ack = 1; chk_hit = 1; tick(); chk_ack = 0; chk_hit = 0;
      chk("t3_lock", lock, 1);
      chk("t3_lock_row", piece_row, 7);
      repeat (5) tick();
      clear_done = 1; tick(); clear_done = 0;
      chk("t3_respawn_req", chk_req, 1);
      chk("t3_respawn_row", chk_row, 0);

      // blocked spawn ends the game
      chk_ack = 1; chk_hit = 1; tick(); chk_ack = 0; chk_hit = 0;
      chk("t4_game_over", game_over, 1);
      move_sig = 1; chk_ack = 1; clear_done = 1;
      repeat (4) tick();
      move_sig = 0; chk_ack = 0; clear_done = 0;
      chk("t4_miss_held", miss_cnt, 25);
      start = 1; tick(); start = 0;
      chk("t4_restart_over", game_over, 0);
      chk("t4_restart_req", chk_req, 1);
      chk("t4_restart_miss", miss_cnt, 0);

      // asynchronous reset in the middle of a check
      chk_ack = 1; tick(); chk_ack = 0;
      fall_to(12);
      move_sig = 1; tick(); move_sig = 0;
      chk("t5_chk_row", chk_row, 13);
      #2 reset = 1;
      #1;
      chk("t5_async_req", chk_req, 0);
      chk("t5_async_row", piece_row, 0);
      chk("t5_async_chk_row", chk_row, 0);
      @(posedge clk); #1 reset = 0;
      chk_ack = 1; tick(); chk_ack = 0;
      tick();
      chk("t5_late_ack_req", chk_req, 0);
      chk("t5_late_ack_row", piece_row, 0);

      // miss counter saturation during a long clear
      start = 1; tick(); start = 0;
      chk_ack = 1; tick(); chk_ack = 0;
      move_sig = 1; tick(); move_sig = 0;
      chk_ack = 1; chk_hit = 1; tick(); chk_ack = 0; chk_hit = 0;
      chk("t6_lock", lock, 1);
      move_sig = 1;
      for (int i = 0; i < 300; i++) begin
         chk_ack = ((i % 7) == 3);
         tick();
      end
      chk_ack = 0; move_sig = 0;
      chk("t6_miss_sat", miss_cnt, 255);
      chk("t6_req_low", chk_req, 0);
      clear_done = 1; tick(); clear_done = 0;
      chk("t6_respawn_req", chk_req, 1);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/drop_ctrl.md
Name: drop_ctrl

Overview:
- Consumer of the periodic fall tick (move_sig) from the auto-drop timer.
- Each accepted tick asks the board logic whether the active piece can move down one row, then advances the piece or locks it.
- After a lock: waits for line-clear, spawns the next piece at the top, and flags game over if the spawn position is blocked.
- Sits between the tick generator and the board/collision logic.

Parameters:
ROWS, 20, number of board rows; valid rows are 0..ROWS-1, floor row is ROWS-1
ROW_W, 5, width of row indices (must hold ROWS-1)
SPAWN_ROW, 0, row a new piece is placed at

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a new game (honoured only in STOP or OVER)
move_sig  in  1  fall request; may stay high for many cycles (fast drop)
chk_req  out  1  collision check request, held until chk_ack
chk_row  out  ROW_W  row under test, stable while chk_req=1
chk_ack  in  1  board response valid (one cycle)
chk_hit  in  1  with chk_ack: 1 = row blocked
clear_done  in  1  board finished line-clear after a lock
piece_row  out  ROW_W  current row of the active piece
lock  out  1  one-cycle pulse: piece fixed at piece_row
spawned  out  1  one-cycle pulse: new piece placed at SPAWN_ROW
game_over  out  1  level, high in OVER
miss_cnt  out  8  saturating count of move_sig cycles ignored while busy

Behaviour:
- One clock domain; all outputs registered.
- Reset (async, immediate, also mid-handshake):
  - state=STOP, piece_row=SPAWN_ROW, miss_cnt=0.
  - chk_req, chk_row, lock, spawned, game_over all 0.
  - Any outstanding check is abandoned.
- States: STOP, SPAWN, RUN, CHECK, LOCK, CLEAR, OVER.
- STOP / OVER:
  - start -> SPAWN; clears miss_cnt and game_over on that same edge.
  - move_sig, chk_ack and clear_done are ignored.
- SPAWN:
  - chk_req=1, chk_row=SPAWN_ROW.
  - On chk_ack with chk_hit=1 -> OVER.
  - On chk_ack with chk_hit=0 -> RUN, piece_row=SPAWN_ROW, spawned pulses 1 cycle.
- RUN, move_sig=1 sampled at edge n:
  - If piece_row < ROWS-1: -> CHECK; chk_req=1 and chk_row=piece_row+1 visible from cycle n+1.
  - If piece_row == ROWS-1 (floor): no check issued; -> LOCK directly.
- CHECK:
  - chk_req and chk_row held stable until chk_ack.
  - On chk_ack at edge m:
    - chk_hit=0: piece_row<=piece_row+1, chk_req<=0, -> RUN.
    - chk_hit=1: chk_req<=0, piece_row unchanged, -> LOCK.
  - Minimum tick-to-move latency: 2 cycles (ack in first req cycle).
  - Held move_sig yields one row per check round-trip, with RUN lasting at least 1 cycle between checks.
- LOCK: lock=1 for exactly one cycle, then -> CLEAR.
- CLEAR: wait for clear_done=1, then -> SPAWN. clear_done already high on CLEAR entry is honoured on the first CLEAR cycle.
- miss_cnt:
  - Increments on every cycle with move_sig=1 in SPAWN, CHECK, LOCK or CLEAR.
  - Saturates at 255.
- Ignored inputs:
  - chk_ack while chk_req=0.
  - start outside STOP/OVER.
- Row arithmetic: ROW_W bits, never wraps; piece_row never exceeds ROWS-1.
- lock and spawned are never high in the same cycle.

Test Plan:
1. Reset, start, ack spawn with hit=0 -> spawned pulse, piece_row=0; single move_sig pulse, ack hit=0 after 3 cycles -> chk_row=1 throughout, piece_row=1 one cycle after ack, chk_req low.
2. move_sig held high, board acks every request immediately with hit=0 -> piece_row steps 0..19. At row 19 the next tick gives lock without chk_req; miss_cnt counts only the busy-cycle overlaps.
3. piece_row=7, tick, ack hit=1 -> lock pulse with piece_row=7; clear_done after 5 cycles -> new SPAWN check on chk_row=0.
4. Spawn check answered hit=1 -> game_over=1, further move_sig ignored. start -> game_over=0, new SPAWN check issued, miss_cnt=0.
5. Assert reset while chk_req=1 in CHECK at piece_row=12 -> all outputs zero and piece_row=0 immediately (before next edge). A late chk_ack after reset release causes no state change.
6. Hold move_sig high for 300 cycles during CLEAR -> miss_cnt saturates at 255. chk_ack pulses with chk_req=0 are ignored.
